// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, owner codes, default widths.
// ARB_ROUND_ROBIN_EN (see arb_pick / mem_port_arbiter) switches fixed data-priority to alternating grants.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_e;

  // one-hot grant vector layout: bit 0 = instruction port, bit 1 = data port
  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_INSTR = 2'b01;
  localparam logic [1:0] GNT_DATA  = 2'b10;

  function automatic logic grant_owner(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Purely combinational grant select between fetch and data requesters; one-hot output.
// ARB_ROUND_ROBIN_EN: contention goes to the port that did not win last; otherwise data always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_instr_vld,
  input  logic       i_data_vld,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

`ifndef ARB_ROUND_ROBIN_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

  always_comb begin
    o_grant = GNT_NONE;
    if (i_instr_vld && i_data_vld) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_grant = (i_last_grant == INSTR) ? GNT_DATA : GNT_INSTR;
`else
      o_grant = GNT_DATA;
`endif
    end else if (i_data_vld) begin
      o_grant = GNT_DATA;
    end else if (i_instr_vld) begin
      o_grant = GNT_INSTR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction in flight; accept N, mem req N+1, rsp pulse M+1.
// Requesters are held off (ready low) outside IDLE; ARB_ROUND_ROBIN_EN selects alternating arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rdata,

  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_we,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [1:0]            w_grant;
  logic                  w_last_grant;
  logic                  w_accept;
  logic                  w_rsp_take;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic                  r_owner;

  logic                  r_i_rsp_vld;
  logic                  r_d_rsp_vld;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= INSTR;
    end else if (w_accept) begin
      r_last_grant <= grant_owner(w_grant);
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = INSTR;
`endif

  arb_pick u_arb_pick (
    .i_instr_vld  (i_req_valid),
    .i_data_vld   (d_req_valid),
    .i_last_grant (w_last_grant),
    .o_grant      (w_grant)
  );

  // Ready and mem_req_valid are masked by rst so nothing handshakes in a reset cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    mem_req_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && (w_grant != GNT_NONE)) begin
          w_accept    = 1'b1;
          i_req_ready = w_grant[0];
          d_req_ready = w_grant[1];
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = !rst;
        if (mem_req_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_owner <= INSTR;
    end else if (w_accept) begin
      if (grant_owner(w_grant) == DATA) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_we    <= d_we;
        r_owner <= DATA;
      end else begin
        r_addr  <= i_addr;
        r_wdata <= '0;
        r_we    <= 1'b0;
        r_owner <= INSTR;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;

  // Responses outside WAIT (stale or spurious) never reach a requester.
  assign w_rsp_take = (r_state == WAIT) && mem_rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_rsp_vld <= 1'b0;
      r_d_rsp_vld <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_rsp_vld <= w_rsp_take && (r_owner == INSTR);
      r_d_rsp_vld <= w_rsp_take && (r_owner == DATA);
      if (w_rsp_take && (r_owner == INSTR)) begin
        r_i_rdata <= mem_rdata;
      end
      if (w_rsp_take && (r_owner == DATA)) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign i_rsp_valid = r_i_rsp_vld;
  assign d_rsp_valid = r_d_rsp_vld;
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: transaction-level model predicts grants, commands and responses.
// Commands and responses go through queues that a separate negedge monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          i_req_valid, i_req_ready, i_rsp_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic we; } cmd_t;
  typedef struct { logic owner; logic [DW-1:0] rdata; int due; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  logic glog[$];

  // Reference model: one transaction outstanding; owner 1 = data port.
  bit   m_out = 0, m_sent = 0, m_last = 0, m_owner = 0;
  int   m_age = 0;
  int   rsp_cnt = 0, hold_cnt = 0;
  int   pi = 0, pd = 0, prdy = 100, rsp_min = 0, rsp_max = 0, pspur = 0;
  bit   use_fix = 0;
  logic [DW-1:0] fix_rdata = '0;
  bit   i_acc = 0, d_acc = 0, mon_en = 0;
  int   n_mem_vld = 0;

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Returns {data_grant, instr_grant} from the arbitration rules.
  function automatic logic [1:0] predict(input logic iv, input logic dv);
    if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
      return m_last ? 2'b01 : 2'b10;
`else
      return 2'b10;
`endif
    end
    return {dv, iv};
  endfunction

  task automatic cycle();
    logic [1:0] g;
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    g = (!m_out && !rst) ? predict(i_req_valid, d_req_valid) : 2'b00;
    chk1("i_req_ready", i_req_ready, g[0]);
    chk1("d_req_ready", d_req_ready, g[1]);
    chk1("mem_req_valid", mem_req_valid, m_out && !m_sent && !rst);
    i_acc = i_req_valid && i_req_ready;
    d_acc = d_req_valid && d_req_ready;
    if (rst) begin
      m_out = 0; m_sent = 0; m_last = 0; m_age = 0;
    end else begin
      if (m_sent && mem_rsp_valid) begin
        r.owner = m_owner; r.rdata = mem_rdata; r.due = cyc + 1;
        rsp_q.push_back(r);
        m_out = 0; m_sent = 0;
      end else if (m_out && !m_sent && mem_req_ready) begin
        m_sent  = 1;
        rsp_cnt = $urandom_range(rsp_max, rsp_min);
      end
      if (g != 2'b00) begin
        m_out = 1; m_owner = g[1]; m_last = g[1]; m_age = 0;
        glog.push_back(g[1]);
        if (g[1]) begin c.addr = d_addr; c.wdata = d_wdata; c.we = d_we; end
        else begin c.addr = i_addr; c.wdata = '0; c.we = 1'b0; end
        cmd_q.push_back(c);
      end
      if (m_out) m_age++;
      if (m_age > 200) begin
        errors++; checks++;
        $display("FAIL watchdog: transaction outstanding %0d cycles, limit 200", m_age);
        finish_run();
      end
    end
    @(posedge clk); #1;
    if (i_acc || !i_req_valid) begin
      i_req_valid = ($urandom_range(99) < pi);
      i_addr      = $urandom;
    end
    if (d_acc || !d_req_valid) begin
      d_req_valid = ($urandom_range(99) < pd);
      d_addr      = $urandom;
      d_wdata     = $urandom;
      d_we        = 1'($urandom_range(1, 0));
    end
    if (hold_cnt > 0) begin
      mem_req_ready = 1'b0;
      hold_cnt--;
    end else begin
      mem_req_ready = ($urandom_range(99) < prdy);
    end
    mem_rsp_valid = 1'b0;
    if (m_sent) begin
      if (rsp_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = use_fix ? fix_rdata : DW'($urandom);
      end else begin
        rsp_cnt--;
      end
    end else if ($urandom_range(99) < pspur) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = $urandom;
    end
  endtask

  task automatic run_idle();
    int k = 0;
    do begin
      cycle();
      k++;
    end while ((m_out || rsp_q.size() != 0 || i_req_valid || d_req_valid) && k < 400);
    chk1("drain_done", m_out || rsp_q.size() != 0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    mem_rsp_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  // Monitor: memory command stability/content and response pulses against queued expectations.
  logic [DW-1:0] e_irdata = '0, e_drdata = '0;
  rsp_t mon_r;
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req_valid) begin
        n_mem_vld++;
        chk1("mem_cmd_expected", cmd_q.size() != 0, 1'b1);
        if (cmd_q.size() != 0) begin
          chkw("mem_addr", mem_addr, cmd_q[0].addr);
          chkw("mem_wdata", mem_wdata, cmd_q[0].wdata);
          chk1("mem_we", mem_we, cmd_q[0].we);
          if (mem_req_ready) void'(cmd_q.pop_front());
        end
      end
      chk1("rsp_not_both", i_rsp_valid & d_rsp_valid, 1'b0);
      if (i_rsp_valid || d_rsp_valid) begin
        chk1("rsp_expected", rsp_q.size() != 0, 1'b1);
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          chki("rsp_cycle", cyc, mon_r.due);
          chk1("rsp_owner", d_rsp_valid, mon_r.owner);
          if (mon_r.owner) e_drdata = mon_r.rdata;
          else             e_irdata = mon_r.rdata;
        end
      end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
        chk1("rsp_missing", i_rsp_valid | d_rsp_valid, 1'b1);
        void'(rsp_q.pop_front());
      end
      chkw("i_rdata", i_rdata, e_irdata);
      chkw("d_rdata", d_rdata, e_drdata);
      if (rst) begin
        cmd_q.delete();
        rsp_q.delete();
        e_irdata = '0;
        e_drdata = '0;
      end
    end
  end

  initial begin
    int n0;
    logic gexp [4];
    rst = 1'b1;
    i_req_valid = 0; i_addr = '0;
    d_req_valid = 0; d_addr = '0; d_wdata = '0; d_we = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_i_req_ready", i_req_ready, 1'b0);
    chk1("rst_d_req_ready", d_req_ready, 1'b0);
    chk1("rst_i_rsp_valid", i_rsp_valid, 1'b0);
    chk1("rst_d_rsp_valid", d_rsp_valid, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chkw("rst_mem_addr", mem_addr, '0);
    chkw("rst_mem_wdata", mem_wdata, '0);
    chkw("rst_i_rdata", i_rdata, '0);
    chkw("rst_d_rdata", d_rdata, '0);
    mon_en = 1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch, fixed response data after a short delay.
    use_fix = 1; fix_rdata = 32'hDEADBEEF; rsp_min = 2; rsp_max = 2; prdy = 100;
    i_req_valid = 1; i_addr = 32'h100;
    run_idle();
    chkw("fetch_rdata", i_rdata, 32'hDEADBEEF);
    chkw("fetch_d_rdata_untouched", d_rdata, '0);

    // Data write with memory stalling for three cycles.
    fix_rdata = 32'h0BADF00D;
    d_req_valid = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_we = 1;
    mem_req_ready = 0; hold_cnt = 3;
    n0 = n_mem_vld;
    run_idle();
    chki("write_issue_cycles", n_mem_vld - n0, 4);
    chkw("write_d_rdata", d_rdata, 32'h0BADF00D);

    // Spurious memory responses while idle.
    pspur = 100;
    repeat (6) cycle();
    pspur = 0;
    chkw("spur_i_rdata", i_rdata, 32'hDEADBEEF);
    chkw("spur_d_rdata", d_rdata, 32'h0BADF00D);

    // Reset while waiting for memory, stale response right after.
    rsp_min = 6; rsp_max = 6;
    d_req_valid = 1; d_addr = 32'h3000; d_wdata = 32'h55AA55AA; d_we = 0;
    for (int k = 0; k < 50 && !m_sent; k++) cycle();
    chk1("reached_wait", m_sent, 1'b1);
    pulse_reset();
    mem_rsp_valid = 1; mem_rdata = 32'hFFFF0000;
    cycle();
    chkw("stale_d_rdata", d_rdata, '0);
    rsp_min = 0; rsp_max = 0; fix_rdata = 32'hC0FFEE00;
    i_req_valid = 1; i_addr = 32'h300;
    run_idle();
    chkw("post_reset_fetch", i_rdata, 32'hC0FFEE00);

    // Back-to-back contention from a fresh reset.
    pulse_reset();
    use_fix = 0; rsp_min = 0; rsp_max = 2; pi = 100; pd = 100;
    glog.delete();
    for (int k = 0; k < 200 && glog.size() < 4; k++) cycle();
    pi = 0; pd = 0;
    run_idle();
`ifdef ARB_ROUND_ROBIN_EN
    gexp[0] = 1; gexp[1] = 0; gexp[2] = 1; gexp[3] = 0;
`else
    gexp[0] = 1; gexp[1] = 1; gexp[2] = 1; gexp[3] = 1;
`endif
    chki("grant_rounds", glog.size() >= 4 ? 4 : glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) chk1($sformatf("grant_round%0d", k), glog[k], gexp[k]);

    // Random traffic with occasional resets.
    for (int blk = 0; blk < 15; blk++) begin
      pi = $urandom_range(100); pd = $urandom_range(100);
      prdy = $urandom_range(100, 10); rsp_min = 0; rsp_max = $urandom_range(4);
      pspur = $urandom_range(30);
      for (int k = 0; k < 100; k++) begin
        cycle();
        if (rst) rst = 1'b0;
        else if (m_out && rsp_q.size() == 0 && $urandom_range(99) < 2) rst = 1'b1;
      end
    end
    rst = 1'b0; pi = 0; pd = 0; pspur = 0; prdy = 100;
    run_idle();
    chki("cmd_q_empty", cmd_q.size(), 0);
    chki("rsp_q_empty", rsp_q.size(), 0);
    finish_run();
  end

endmodule
